// File: rtl/alu_issue_if.sv
`default_nettype none
// ============================================================================
// Interface : alu_issue_if
// Purpose   : Bundles the request, response and ALU-side signals of the
//             alu_issue block.
// Modports  : slave  - the issue block (accepts requests, drives ALU operands,
//                      returns responses)
//             master - the environment (offers requests, consumes responses,
//                      provides the ALU result)
// Signals   : req_valid/req_ready, req_instr[13:0], req_a/req_b[19:0],
//             req_cin, req_chain, alu_instruction[13:0], alu_a/alu_b[19:0],
//             alu_cin, alu_result[19:0], alu_carry_out, rsp_valid/rsp_ready,
//             rsp_result[19:0], rsp_carry, busy
// Revision  : 1.0 - initial release
// ============================================================================
interface alu_issue_if;
  // request channel
  logic        req_valid;
  logic        req_ready;
  logic [13:0] req_instr;
  logic [19:0] req_a;
  logic [19:0] req_b;
  logic        req_cin;
  logic        req_chain;

  // ALU side
  logic [13:0] alu_instruction;
  logic [19:0] alu_a;
  logic [19:0] alu_b;
  logic        alu_cin;
  logic [19:0] alu_result;
  logic        alu_carry_out;

  // response channel
  logic        rsp_valid;
  logic        rsp_ready;
  logic [19:0] rsp_result;
  logic        rsp_carry;

  // status
  logic        busy;

  modport slave (
    input  req_valid, req_instr, req_a, req_b, req_cin, req_chain,
    output req_ready,
    output alu_instruction, alu_a, alu_b, alu_cin,
    input  alu_result, alu_carry_out,
    output rsp_valid, rsp_result, rsp_carry,
    input  rsp_ready,
    output busy
  );

  modport master (
    output req_valid, req_instr, req_a, req_b, req_cin, req_chain,
    input  req_ready,
    input  alu_instruction, alu_a, alu_b, alu_cin,
    output alu_result, alu_carry_out,
    input  rsp_valid, rsp_result, rsp_carry,
    output rsp_ready,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module    : alu_issue
// Purpose   : Single-outstanding issue stage for a multi-cycle ALU. Accepts
//             one request, holds the operands on the ALU inputs, waits
//             ALU_LATENCY cycles, captures the ALU result and offers it on a
//             valid/ready response channel.
// Ports     : clk          - clock, all state changes on rising edge
//             rst_n        - asynchronous active-low reset
//             bus (slave)  - request / ALU / response / busy signals
// Params    : ALU_LATENCY  - cycles from operands stable to result sampled
//                            (legal range 1..15)
// Options   : ALU_ISSUE_CARRY_CHAIN_EN - when defined, a chain register keeps
//             the carry of the last completed response and req_chain selects
//             it as the carry-in of the next operation.
// Revision  : 1.0 - initial release
// ============================================================================
module alu_issue #(
  parameter int ALU_LATENCY = 1
) (
  input  wire logic  clk,
  input  wire logic  rst_n,
  alu_issue_if.slave bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_EXEC = 2'd1;
  localparam logic [1:0] c_S_RESP = 2'd2;

  localparam logic [3:0] c_LAT = 4'(ALU_LATENCY);

  // --------------------------------------------------------------------------
  // Declarations
  // --------------------------------------------------------------------------
  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;

  logic [3:0]  r_cnt;
  logic [13:0] r_alu_instr;
  logic [19:0] r_alu_a;
  logic [19:0] r_alu_b;
  logic        r_alu_cin;
  logic [19:0] r_rsp_result;
  logic        r_rsp_carry;

  logic        w_accept;
  logic        w_capture;
  logic        w_rsp_hs;
  logic        w_cin_sel;

  logic        w_req_ready;
  logic        w_rsp_valid;
  logic        w_busy;

  // --------------------------------------------------------------------------
  // Control events
  // --------------------------------------------------------------------------
  assign w_accept  = (r_state == c_S_IDLE) && bus.req_valid;
  // The count is never below 1 while in EXEC; "<= 1" keeps the FSM from
  // stalling should the counter ever be corrupted.
  assign w_capture = (r_state == c_S_EXEC) && (r_cnt <= 4'd1);
  assign w_rsp_hs  = (r_state == c_S_RESP) && bus.rsp_ready;

  // --------------------------------------------------------------------------
  // Carry-in selection
  // --------------------------------------------------------------------------
`ifdef ALU_ISSUE_CARRY_CHAIN_EN
  logic r_chain;

  // The chain register follows completed responses only, so an operation
  // discarded by reset never contributes its carry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= 1'b0;
    end else if (w_rsp_hs) begin
      r_chain <= r_rsp_carry;
    end
  end

  assign w_cin_sel = bus.req_chain ? r_chain : bus.req_cin;
`else
  logic w_unused_chain;

  assign w_unused_chain = bus.req_chain;
  assign w_cin_sel      = bus.req_cin;
`endif

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_S_IDLE: begin
        if (bus.req_valid) begin
          w_state_nxt = c_S_EXEC;
        end
      end
      c_S_EXEC: begin
        if (r_cnt <= 4'd1) begin
          w_state_nxt = c_S_RESP;
        end
      end
      c_S_RESP: begin
        if (bus.rsp_ready) begin
          w_state_nxt = c_S_IDLE;
        end
      end
      default: begin
        w_state_nxt = c_S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_req_ready = 1'b0;
    w_rsp_valid = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      c_S_IDLE: begin
        w_req_ready = 1'b1;
        w_busy      = 1'b0;
      end
      c_S_EXEC: begin
        w_req_ready = 1'b0;
      end
      c_S_RESP: begin
        w_rsp_valid = 1'b1;
      end
      default: begin
        w_req_ready = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: operand hold, countdown and result capture
  // --------------------------------------------------------------------------
  // Operands are loaded only on acceptance, so they stay on the ALU inputs
  // through EXEC, RESP and the following IDLE period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= 4'd0;
      r_alu_instr  <= 14'd0;
      r_alu_a      <= 20'd0;
      r_alu_b      <= 20'd0;
      r_alu_cin    <= 1'b0;
      r_rsp_result <= 20'd0;
      r_rsp_carry  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_alu_instr <= bus.req_instr;
        r_alu_a     <= bus.req_a;
        r_alu_b     <= bus.req_b;
        r_alu_cin   <= w_cin_sel;
        r_cnt       <= c_LAT;
      end else if ((r_state == c_S_EXEC) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (w_capture) begin
        r_rsp_result <= bus.alu_result;
        r_rsp_carry  <= bus.alu_carry_out;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output drive
  // --------------------------------------------------------------------------
  assign bus.req_ready       = w_req_ready;
  assign bus.rsp_valid       = w_rsp_valid;
  assign bus.busy            = w_busy;
  assign bus.alu_instruction = r_alu_instr;
  assign bus.alu_a           = r_alu_a;
  assign bus.alu_b           = r_alu_b;
  assign bus.alu_cin         = r_alu_cin;
  assign bus.rsp_result      = r_rsp_result;
  assign bus.rsp_carry       = r_rsp_carry;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module    : tb_alu_issue
// Purpose   : Self-checking bench for alu_issue. Four instances with
//             ALU_LATENCY = 1, 3, 4 and 15 share one request stream; a
//             timestamp-based model predicts every output and is compared on
//             each falling clock edge, and directed literal checks pin the
//             model. Honours ALU_ISSUE_CARRY_CHAIN_EN.
// Revision  : 1.0 - initial release
// ============================================================================
module tb_alu_issue;

  localparam int N = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;

  // shared stimulus
  logic        t_v     = 1'b0;
  logic [13:0] t_instr = 14'd0;
  logic [19:0] t_a     = 20'd0;
  logic [19:0] t_b     = 20'd0;
  logic        t_cin   = 1'b0;
  logic        t_chain = 1'b0;
  logic        t_rr    = 1'b1;

  int n_checks = 0;
  int n_fail   = 0;
  int hs_cnt0  = 0;

  // gathered DUT outputs, indexed by instance
  logic        o_rdy [N];
  logic        o_busy[N];
  logic        o_rv  [N];
  logic        o_rc  [N];
  logic [19:0] o_res [N];
  logic [13:0] o_ai  [N];
  logic [19:0] o_aa  [N];
  logic [19:0] o_ab  [N];
  logic        o_ac  [N];

  always #5 clk = ~clk;

  function automatic int lat_of(input int i);
    case (i)
      0: return 1;
      1: return 3;
      2: return 4;
      default: return 15;
    endcase
  endfunction

  // --------------------------------------------------------------------------
  // DUT instances and behavioural ALU (result = A + B + cin, carry = bit 20)
  // --------------------------------------------------------------------------
  alu_issue_if b0 ();
  alu_issue_if b1 ();
  alu_issue_if b2 ();
  alu_issue_if b3 ();

  alu_issue #(.ALU_LATENCY(1))  u_dut0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  alu_issue #(.ALU_LATENCY(3))  u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  alu_issue #(.ALU_LATENCY(4))  u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));
  alu_issue #(.ALU_LATENCY(15)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

  assign {b0.req_valid, b0.req_instr, b0.req_a, b0.req_b, b0.req_cin, b0.req_chain, b0.rsp_ready} = {t_v, t_instr, t_a, t_b, t_cin, t_chain, t_rr};
  assign {b1.req_valid, b1.req_instr, b1.req_a, b1.req_b, b1.req_cin, b1.req_chain, b1.rsp_ready} = {t_v, t_instr, t_a, t_b, t_cin, t_chain, t_rr};
  assign {b2.req_valid, b2.req_instr, b2.req_a, b2.req_b, b2.req_cin, b2.req_chain, b2.rsp_ready} = {t_v, t_instr, t_a, t_b, t_cin, t_chain, t_rr};
  assign {b3.req_valid, b3.req_instr, b3.req_a, b3.req_b, b3.req_cin, b3.req_chain, b3.rsp_ready} = {t_v, t_instr, t_a, t_b, t_cin, t_chain, t_rr};

  assign {b0.alu_carry_out, b0.alu_result} = {1'b0, b0.alu_a} + {1'b0, b0.alu_b} + {20'd0, b0.alu_cin};
  assign {b1.alu_carry_out, b1.alu_result} = {1'b0, b1.alu_a} + {1'b0, b1.alu_b} + {20'd0, b1.alu_cin};
  assign {b2.alu_carry_out, b2.alu_result} = {1'b0, b2.alu_a} + {1'b0, b2.alu_b} + {20'd0, b2.alu_cin};
  assign {b3.alu_carry_out, b3.alu_result} = {1'b0, b3.alu_a} + {1'b0, b3.alu_b} + {20'd0, b3.alu_cin};

  assign {o_rdy[0], o_busy[0], o_rv[0], o_rc[0], o_res[0], o_ai[0], o_aa[0], o_ab[0], o_ac[0]} = {b0.req_ready, b0.busy, b0.rsp_valid, b0.rsp_carry, b0.rsp_result, b0.alu_instruction, b0.alu_a, b0.alu_b, b0.alu_cin};
  assign {o_rdy[1], o_busy[1], o_rv[1], o_rc[1], o_res[1], o_ai[1], o_aa[1], o_ab[1], o_ac[1]} = {b1.req_ready, b1.busy, b1.rsp_valid, b1.rsp_carry, b1.rsp_result, b1.alu_instruction, b1.alu_a, b1.alu_b, b1.alu_cin};
  assign {o_rdy[2], o_busy[2], o_rv[2], o_rc[2], o_res[2], o_ai[2], o_aa[2], o_ab[2], o_ac[2]} = {b2.req_ready, b2.busy, b2.rsp_valid, b2.rsp_carry, b2.rsp_result, b2.alu_instruction, b2.alu_a, b2.alu_b, b2.alu_cin};
  assign {o_rdy[3], o_busy[3], o_rv[3], o_rc[3], o_res[3], o_ai[3], o_aa[3], o_ab[3], o_ac[3]} = {b3.req_ready, b3.busy, b3.rsp_valid, b3.rsp_carry, b3.rsp_result, b3.alu_instruction, b3.alu_a, b3.alu_b, b3.alu_cin};

  // --------------------------------------------------------------------------
  // Checking helper
  // --------------------------------------------------------------------------
  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] t=%0t actual=0x%0h required=0x%0h", name, idx, $time, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Model: an operation is in flight from its accept edge until its response
  // handshake; its response is visible once ALU_LATENCY edges have elapsed
  // since acceptance.
  // --------------------------------------------------------------------------
  logic        m_inf  [N];
  logic        m_val  [N];
  logic        m_cin  [N];
  logic        m_chain[N];
  logic [13:0] m_instr[N];
  logic [19:0] m_a    [N];
  logic [19:0] m_b    [N];
  logic [20:0] m_sum  [N];
  int          t_acc  [N];
  int          now = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_inf[i]   <= 1'b0;
        m_val[i]   <= 1'b0;
        m_cin[i]   <= 1'b0;
        m_chain[i] <= 1'b0;
        m_instr[i] <= 14'd0;
        m_a[i]     <= 20'd0;
        m_b[i]     <= 20'd0;
        m_sum[i]   <= 21'd0;
        t_acc[i]   <= 0;
      end
    end else begin
      now <= now + 1;
      for (int i = 0; i < N; i++) begin
        if (!m_inf[i]) begin
          if (t_v) begin
            m_inf[i]   <= 1'b1;
            t_acc[i]   <= now + 1;
            m_instr[i] <= t_instr;
            m_a[i]     <= t_a;
            m_b[i]     <= t_b;
`ifdef ALU_ISSUE_CARRY_CHAIN_EN
            m_cin[i]   <= t_chain ? m_chain[i] : t_cin;
            m_sum[i]   <= {1'b0, t_a} + {1'b0, t_b} + {20'd0, (t_chain ? m_chain[i] : t_cin)};
`else
            m_cin[i]   <= t_cin;
            m_sum[i]   <= {1'b0, t_a} + {1'b0, t_b} + {20'd0, t_cin};
`endif
          end
          m_val[i] <= 1'b0;
        end else if (m_val[i] && t_rr) begin
          m_inf[i]   <= 1'b0;
          m_val[i]   <= 1'b0;
          m_chain[i] <= m_sum[i][20];
        end else begin
          m_val[i] <= ((now + 1 - t_acc[i]) >= lat_of(i));
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Per-cycle comparison against the model
  // --------------------------------------------------------------------------
  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      check("req_ready", i, 32'(o_rdy[i]),  32'(!m_inf[i]));
      check("busy",      i, 32'(o_busy[i]), 32'(m_inf[i]));
      check("rsp_valid", i, 32'(o_rv[i]),   32'(m_val[i]));
      check("alu_instr", i, 32'(o_ai[i]),   32'(m_instr[i]));
      check("alu_a",     i, 32'(o_aa[i]),   32'(m_a[i]));
      check("alu_b",     i, 32'(o_ab[i]),   32'(m_b[i]));
      check("alu_cin",   i, 32'(o_ac[i]),   32'(m_cin[i]));
      if (m_val[i]) begin
        check("rsp_result", i, 32'(o_res[i]), 32'(m_sum[i][19:0]));
        check("rsp_carry",  i, 32'(o_rc[i]),  32'(m_sum[i][20]));
      end
    end
  end

  always @(posedge clk) begin
    if (o_rv[0] && t_rr) begin
      hs_cnt0 <= hs_cnt0 + 1;
    end
  end

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one request for a single cycle; returns one step after its edge.
  task automatic issue(input logic [13:0] ins, input logic [19:0] a, input logic [19:0] b, input logic cin, input logic chain);
    t_v = 1'b1; t_instr = ins; t_a = a; t_b = b; t_cin = cin; t_chain = chain;
    tick();
    t_v = 1'b0;
  endtask

  task automatic wait_rsp0();
    int k;
    k = 0;
    while (!o_rv[0] && k < 40) begin
      tick();
      k++;
    end
    check("rsp0_wait_bound", 0, 32'(k < 40), 32'd1);
  endtask

  task automatic wait_all_idle();
    int k;
    k = 0;
    while ((o_busy[0] || o_busy[1] || o_busy[2] || o_busy[3]) && k < 100) begin
      tick();
      k++;
    end
    check("idle_wait_bound", 0, 32'(k < 100), 32'd1);
  endtask

  initial begin
    int base;
    int cnt;
    int lat[N];

    // reset and idle
    #1 rst_n = 1'b0;
    tick();
    tick();
    check("rst_req_ready", 0, 32'(o_rdy[0]), 32'd1);
    check("rst_busy",      0, 32'(o_busy[0]), 32'd0);
    check("rst_rsp_valid", 0, 32'(o_rv[0]), 32'd0);
    check("rst_outputs",   0, {11'd0, o_res[0], o_ac[0]}, 32'd0);
    check("rst_alu_a",     0, 32'(o_aa[0]), 32'd0);
    rst_n = 1'b1;
    tick();

    // single operation, latency 1
    issue(14'h018E, 20'h00155, 20'h0000F, 1'b1, 1'b0);
    check("op1_alu_instr", 0, 32'(o_ai[0]), 32'h018E);
    check("op1_alu_a",     0, 32'(o_aa[0]), 32'h00155);
    check("op1_alu_cin",   0, 32'(o_ac[0]), 32'd1);
    check("op1_early_rv",  0, 32'(o_rv[0]), 32'd0);
    tick();
    check("op1_rsp_valid", 0, 32'(o_rv[0]), 32'd1);
    check("op1_result",    0, 32'(o_res[0]), 32'h00165);
    check("op1_carry",     0, 32'(o_rc[0]), 32'd0);
    wait_all_idle();

    // back-pressure with req_valid held high
    base  = hs_cnt0;
    t_rr  = 1'b0;
    t_v   = 1'b1; t_instr = 14'h0A5A; t_a = 20'h12345; t_b = 20'h0ABCD; t_cin = 1'b0; t_chain = 1'b0;
    tick();
    wait_rsp0();
    for (int c = 0; c < 5; c++) begin
      tick();
      check("bp_rsp_valid", c, 32'(o_rv[0]), 32'd1);
      check("bp_result",    c, 32'(o_res[0]), 32'h1CF12);
      check("bp_req_ready", c, 32'(o_rdy[0]), 32'd0);
    end
    t_v  = 1'b0;
    t_rr = 1'b1;
    wait_all_idle();
    tick();
    check("bp_one_response", 0, 32'(hs_cnt0 - base), 32'd1);

    // carry chain
    issue(14'h0001, 20'hFFFFF, 20'h00001, 1'b0, 1'b0);
    wait_rsp0();
    check("chain1_result", 0, 32'(o_res[0]), 32'h00000);
    check("chain1_carry",  0, 32'(o_rc[0]), 32'd1);
    wait_all_idle();
    issue(14'h0001, 20'h00000, 20'h00000, 1'b0, 1'b1);
    wait_rsp0();
`ifdef ALU_ISSUE_CARRY_CHAIN_EN
    check("chain2_result", 0, 32'(o_res[0]), 32'h00001);
`else
    check("chain2_result", 0, 32'(o_res[0]), 32'h00000);
`endif
    check("chain2_carry",  0, 32'(o_rc[0]), 32'd0);
    wait_all_idle();

    // reset during EXEC of the latency-4 instance
    issue(14'h0022, 20'h00010, 20'h00020, 1'b0, 1'b0);
    tick();
    tick();
    check("mid_exec_busy", 2, 32'(o_busy[2]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_ready", 2, 32'(o_rdy[2]), 32'd1);
    check("rst_async_alu_a", 2, 32'(o_aa[2]), 32'd0);
    tick();
    rst_n = 1'b1;
    cnt = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (o_rv[2]) cnt++;
    end
    check("rst_no_response", 2, 32'(cnt), 32'd0);
    check("rst_idle_ready",  2, 32'(o_rdy[2]), 32'd1);

    // latency sweep
    for (int i = 0; i < N; i++) lat[i] = 0;
    issue(14'h0100, 20'h00003, 20'h00004, 1'b1, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      for (int i = 0; i < N; i++) begin
        if (lat[i] == 0 && o_rv[i]) lat[i] = k + 1;
      end
    end
    check("latency_L1",  0, 32'(lat[0]), 32'd2);
    check("latency_L3",  1, 32'(lat[1]), 32'd4);
    check("latency_L4",  2, 32'(lat[2]), 32'd5);
    check("latency_L15", 3, 32'(lat[3]), 32'd16);
    wait_all_idle();

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog t=%0t actual=running required=finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
